muldiv32: RTL and testbench

//  Iterative 32-bit multiply/divide unit beside the execute-stage ALU of the multicycle MIPS core.

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/muldiv_if.sv | 40 ++++
 rtl/muldiv_sign_fix.sv | 13 +
 rtl/muldiv32.sv | 159 +++++++++++++++
 tb/tb_muldiv32.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Optional divide-by-zero flag: define MULDIV_DIV0_FLAG_EN.
package muldiv_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } muldiv_op_t;

    typedef logic [1:0] md_state_t;
    localparam md_state_t MD_IDLE = 2'd0;
    localparam md_state_t MD_RUN  = 2'd1;
    localparam md_state_t MD_DONE = 2'd2;

endpackage

// File: rtl/muldiv_if.sv
// Operand/result bundle between the execute stage and muldiv32.
// The div0 member exists only when MULDIV_DIV0_FLAG_EN is defined.
interface muldiv_if #(parameter int WIDTH = muldiv_pkg::MD_WIDTH);
    import muldiv_pkg::*;

    // start is taken only while busy is low; once taken, busy stays high until
    // the cycle after the single-cycle done pulse, and hi/lo are valid with done.
    logic             start;
    muldiv_op_t       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    md_state_t        state;
`ifdef MULDIV_DIV0_FLAG_EN
    logic             div0;
`endif

    modport master (
`ifdef MULDIV_DIV0_FLAG_EN
        input  div0,
`endif
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo, state
    );

    modport slave (
`ifdef MULDIV_DIV0_FLAG_EN
        output div0,
`endif
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, hi, lo, state
    );

endinterface

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate, used both to take operand magnitudes
// and to restore the sign of the final result.
module muldiv_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] x_i,
    input  logic         neg_i,
    output logic [W-1:0] y_o
);

    assign y_o = neg_i ? ((~x_i) + W'(1)) : x_i;

endmodule

// File: rtl/muldiv32.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO registers, one bit per cycle.
// Define MULDIV_DIV0_FLAG_EN to add a sticky divide-by-zero flag (div0).
module muldiv32
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    md_state_t          state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               div_q, div_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic               bz_q, bz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
`ifdef MULDIV_DIV0_FLAG_EN
    logic               div0_q, div0_d;
`endif

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs;

    assign a_neg = ~bus.op[0] & bus.a[WIDTH-1];
    assign b_neg = ~bus.op[0] & bus.b[WIDTH-1];

    muldiv_sign_fix #(.W(WIDTH)) u_abs_a (.x_i(bus.a), .neg_i(a_neg), .y_o(a_abs));
    muldiv_sign_fix #(.W(WIDTH)) u_abs_b (.x_i(bus.b), .neg_i(b_neg), .y_o(b_abs));

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     div_diff;
    logic               qbit;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] step;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, dvs_q & {WIDTH{acc_q[0]}}};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff = rem_sh - {1'b0, dvs_q};
    assign qbit     = ~div_diff[WIDTH];
    assign div_next = {(qbit ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], qbit};
    assign step     = div_q ? div_next : mul_next;

    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s;

    muldiv_sign_fix #(.W(2*WIDTH)) u_fix_prod (.x_i(step), .neg_i(sa_q ^ sb_q), .y_o(prod_s));
    muldiv_sign_fix #(.W(WIDTH))   u_fix_quo  (.x_i(step[WIDTH-1:0]), .neg_i(sa_q ^ sb_q), .y_o(quo_s));
    muldiv_sign_fix #(.W(WIDTH))   u_fix_rem  (.x_i(step[2*WIDTH-1:WIDTH]), .neg_i(sa_q), .y_o(rem_s));

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        dvs_d   = dvs_q;
        div_d   = div_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        bz_d    = bz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef MULDIV_DIV0_FLAG_EN
        div0_d  = div0_q;
`endif
        case (state_q)
            MD_IDLE: begin
                if (bus.hi_we) hi_d = bus.wdata;
                if (bus.lo_we) lo_d = bus.wdata;
                if (bus.start) begin
                    state_d = MD_RUN;
                    count_d = '0;
                    acc_d   = {{WIDTH{1'b0}}, a_abs};
                    dvs_d   = b_abs;
                    div_d   = bus.op[1];
                    sa_d    = a_neg;
                    sb_d    = b_neg;
                    bz_d    = (bus.b == '0);
`ifdef MULDIV_DIV0_FLAG_EN
                    div0_d  = 1'b0;
`endif
                end
            end
            MD_RUN: begin
                acc_d   = step;
                count_d = count_q + 1'b1;
                if (count_q == LAST) begin
                    state_d = MD_DONE;
                    if (div_q) begin
                        // Zero divisor: remainder path already reproduces a; quotient forced to all ones.
                        hi_d = rem_s;
                        lo_d = bz_q ? '1 : quo_s;
`ifdef MULDIV_DIV0_FLAG_EN
                        div0_d = bz_q;
`endif
                    end else begin
                        hi_d = prod_s[2*WIDTH-1:WIDTH];
                        lo_d = prod_s[WIDTH-1:0];
                    end
                end
            end
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_IDLE;
            count_q <= '0;
            acc_q   <= '0;
            dvs_q   <= '0;
            div_q   <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            bz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef MULDIV_DIV0_FLAG_EN
            div0_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            dvs_q   <= dvs_d;
            div_q   <= div_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            bz_q    <= bz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef MULDIV_DIV0_FLAG_EN
            div0_q  <= div0_d;
`endif
        end
    end

    assign bus.busy  = (state_q != MD_IDLE);
    assign bus.done  = (state_q == MD_DONE);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.state = state_q;
`ifdef MULDIV_DIV0_FLAG_EN
    assign bus.div0  = div0_q;
`endif

endmodule

// File: tb/tb_muldiv32.sv
// Directed bench for muldiv32: vector table of hand-computed results plus
// hand-written sequences for MTHI/MTLO, ignored starts/writes and mid-run reset.
module tb_muldiv32;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_if bus ();

    muldiv32 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        muldiv_op_t  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t vecs[12];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Waits (bounded) for done; c0 is the cycle index at entry, done is due at cycle 33.
    task automatic wait_done(input string name, input int c0, output int c);
        c = c0;
        while (!bus.done && c < 60) begin
            @(negedge clk);
            c++;
        end
        check(name, 64'(c), 64'd33);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = v.op;
        bus.a     = v.a;
        bus.b     = v.b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = muldiv_op_t'($urandom_range(0, 3));
        bus.a     = $urandom;
        bus.b     = $urandom;
`ifdef MULDIV_DIV0_FLAG_EN
        check($sformatf("v%0d div0 cleared on start", idx), 64'(bus.div0), 64'd0);
`endif
        wait_done($sformatf("v%0d done cycle", idx), 1, cyc);
        check($sformatf("v%0d hi", idx), 64'(bus.hi), 64'(v.hi));
        check($sformatf("v%0d lo", idx), 64'(bus.lo), 64'(v.lo));
`ifdef MULDIV_DIV0_FLAG_EN
        check($sformatf("v%0d div0 at done", idx), 64'(bus.div0), 64'(v.dz));
`endif
        @(negedge clk);
        check($sformatf("v%0d busy at 34", idx), 64'(bus.busy), 64'd0);
`ifdef MULDIV_DIV0_FLAG_EN
        check($sformatf("v%0d div0 held", idx), 64'(bus.div0), 64'(v.dz));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int pulses;

        vecs[0]  = '{op: MD_MULTU, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, hi: 32'hFFFFFFFE, lo: 32'h00000001, dz: 1'b0};
        vecs[1]  = '{op: MD_MULT,  a: 32'hFFFFFFFD, b: 32'h00000007, hi: 32'hFFFFFFFF, lo: 32'hFFFFFFEB, dz: 1'b0};
        vecs[2]  = '{op: MD_DIV,   a: 32'hFFFFFFF9, b: 32'h00000002, hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFD, dz: 1'b0};
        vecs[3]  = '{op: MD_DIVU,  a: 32'd100,      b: 32'd7,        hi: 32'd2,        lo: 32'd14,       dz: 1'b0};
        vecs[4]  = '{op: MD_DIVU,  a: 32'd100,      b: 32'd0,        hi: 32'd100,      lo: 32'hFFFFFFFF, dz: 1'b1};
        vecs[5]  = '{op: MD_DIV,   a: 32'h80000000, b: 32'hFFFFFFFF, hi: 32'h00000000, lo: 32'h80000000, dz: 1'b0};
        vecs[6]  = '{op: MD_MULT,  a: 32'h80000000, b: 32'h80000000, hi: 32'h40000000, lo: 32'h00000000, dz: 1'b0};
        vecs[7]  = '{op: MD_DIV,   a: 32'h00000007, b: 32'hFFFFFFFE, hi: 32'h00000001, lo: 32'hFFFFFFFD, dz: 1'b0};
        vecs[8]  = '{op: MD_DIV,   a: 32'hFFFFFFFB, b: 32'h00000000, hi: 32'hFFFFFFFB, lo: 32'hFFFFFFFF, dz: 1'b1};
        vecs[9]  = '{op: MD_MULTU, a: 32'h12345678, b: 32'h00000010, hi: 32'h00000001, lo: 32'h23456780, dz: 1'b0};
        vecs[10] = '{op: MD_MULT,  a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, hi: 32'h00000000, lo: 32'h00000001, dz: 1'b0};
        vecs[11] = '{op: MD_DIVU,  a: 32'hFFFFFFFF, b: 32'h00000001, hi: 32'h00000000, lo: 32'hFFFFFFFF, dz: 1'b0};

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = MD_MULT;
        bus.a     = '0;
        bus.b     = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset busy",  64'(bus.busy),  64'd0);
        check("reset done",  64'(bus.done),  64'd0);
        check("reset hi",    64'(bus.hi),    64'd0);
        check("reset lo",    64'(bus.lo),    64'd0);
        check("reset state", 64'(bus.state), 64'(MD_IDLE));
`ifdef MULDIV_DIV0_FLAG_EN
        check("reset div0",  64'(bus.div0),  64'd0);
`endif

        // MTHI / MTLO while idle
        bus.hi_we = 1'b1; bus.wdata = 32'hCAFEF00D;
        @(negedge clk);
        bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'h0BADBEEF;
        @(negedge clk);
        bus.lo_we = 1'b0;
        check("mthi", 64'(bus.hi), 64'hCAFEF00D);
        check("mtlo", 64'(bus.lo), 64'h0BADBEEF);

        // start with same-cycle MTHI/MTLO, then writes and starts while busy
        cyc = 0;
        bus.start = 1'b1; bus.op = MD_MULTU; bus.a = 32'h80000001; bus.b = 32'd6;
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h00005555;
        @(negedge clk); cyc = 1;
        bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        check("start+mthi hi", 64'(bus.hi), 64'h5555);
        check("start+mtlo lo", 64'(bus.lo), 64'h5555);
        check("run busy",      64'(bus.busy), 64'd1);
        check("run state",     64'(bus.state), 64'(MD_RUN));
        @(negedge clk); cyc = 2;
        @(negedge clk); cyc = 3;
        bus.hi_we = 1'b1; bus.wdata = 32'h00009999;
        @(negedge clk); cyc = 4;
        bus.hi_we = 1'b0;
        check("mthi while busy", 64'(bus.hi), 64'h5555);
        @(negedge clk); cyc = 5;
        bus.start = 1'b1; bus.op = MD_DIV; bus.a = 32'd50; bus.b = 32'd3;
        @(negedge clk); cyc = 6;
        bus.start = 1'b0;
        wait_done("busy seq done cycle", cyc, cyc);
        check("busy seq hi", 64'(bus.hi), 64'h3);
        check("busy seq lo", 64'(bus.lo), 64'h6);
        bus.start = 1'b1; bus.op = MD_MULTU; bus.a = 32'd2; bus.b = 32'd2;
        @(negedge clk);
        bus.start = 1'b0;
        check("start in DONE ignored @34", 64'(bus.busy), 64'd0);
        @(negedge clk);
        check("start in DONE not queued", 64'(bus.busy), 64'd0);

        // start@0, start@5, MTHI@6, reset@10
        bus.start = 1'b1; bus.op = MD_MULTU; bus.a = 32'hFFFF0000; bus.b = 32'h00FF00FF;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.start = 1'b1; bus.op = MD_DIVU; bus.a = 32'd9; bus.b = 32'd2;
        @(negedge clk);
        bus.start = 1'b0; bus.hi_we = 1'b1; bus.wdata = 32'h00001234;
        @(negedge clk);
        bus.hi_we = 1'b0;
        check("mthi@6 ignored", 64'(bus.hi), 64'h3);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort busy", 64'(bus.busy), 64'd0);
        check("abort done", 64'(bus.done), 64'd0);
        check("abort hi",   64'(bus.hi),   64'd0);
        check("abort lo",   64'(bus.lo),   64'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        check("no done after abort", 64'(pulses), 64'd0);
        check("idle after abort", 64'(bus.busy), 64'd0);

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
